vga_scroll_engine: RTL

VGA_SCROLL_ENGINE -- requirements
Module: vga_scroll_engine

---
 rtl/vga_scroll_engine.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_scroll_engine.sv
// Text-buffer scroll engine: copies rows up by n, clears the vacated tail with a fill word.
// state | meaning:  IDLE wait start | RD read src | CAP capture | WR write dst | CLR fill tail | DONE pulse
module vga_scroll_engine #(
  parameter int N_WORDS   = 600,
  parameter int ROW_WORDS = 20,
  parameter int DATA_W    = 28,
  parameter int ADDR_W    = 10
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [4:0]        lines_i,
  input  logic [DATA_W-1:0] fill_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              host_wr_en_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic [3:0]        host_strb_i,
  output logic              buf_wr_en_o,
  output logic [ADDR_W-1:0] buf_waddr_o,
  output logic [DATA_W-1:0] buf_wdata_o,
  output logic [3:0]        buf_wstrb_o,
  output logic              buf_rd_en_o,
  output logic [ADDR_W-1:0] buf_raddr_o,
  input  logic [DATA_W-1:0] buf_rdata_i
);

  localparam int IW = ADDR_W + 1;
  localparam logic [4:0]    MAX_ROWS = 5'(N_WORDS / ROW_WORDS);
  localparam logic [IW-1:0] NW       = IW'(N_WORDS);
  localparam logic [IW-1:0] LAST     = IW'(N_WORDS - 1);
  localparam logic [IW-1:0] RW       = IW'(ROW_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_CLR, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4:0]        n_q, n_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic [4:0]        lines_sat;
  logic [IW-1:0]     src_off;
  logic [IW-1:0]     copy_cnt;
  logic [IW-1:0]     idx_inc;
  logic              eng_wr;

  // Offsets kept one bit wider than the address so K and S never wrap.
  assign lines_sat = (lines_i > MAX_ROWS) ? MAX_ROWS : lines_i;
  assign src_off   = IW'(n_q) * RW;
  assign copy_cnt  = NW - src_off;
  assign idx_inc   = idx_q + IW'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    fill_d      = fill_q;
    hold_d      = hold_q;
    eng_wr      = 1'b0;
    buf_rd_en_o = 1'b0;
    buf_raddr_o = '0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_d    = lines_sat;
          fill_d = fill_i;
          idx_d  = '0;
          if (lines_sat == 5'd0)          state_d = S_DONE;
          else if (lines_sat == MAX_ROWS) state_d = S_CLR;
          else                            state_d = S_RD;
        end
      end
      S_RD: begin
        buf_rd_en_o = 1'b1;
        buf_raddr_o = ADDR_W'(idx_q + src_off);
        state_d     = S_CAP;
      end
      S_CAP: begin
        hold_d  = buf_rdata_i;
        state_d = S_WR;
      end
      S_WR: begin
        // Host owns the write port this cycle; retry next cycle with the same hold word.
        if (!host_wr_en_i) begin
          eng_wr = 1'b1;
          if (idx_inc < copy_cnt) begin
            idx_d   = idx_inc;
            state_d = S_RD;
          end else begin
            idx_d   = copy_cnt;
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        if (!host_wr_en_i) begin
          eng_wr = 1'b1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign buf_wr_en_o = host_wr_en_i | eng_wr;
  assign buf_waddr_o = host_wr_en_i ? host_addr_i : idx_q[ADDR_W-1:0];
  assign buf_wdata_o = host_wr_en_i ? host_data_i : ((state_q == S_CLR) ? fill_q : hold_q);
  assign buf_wstrb_o = host_wr_en_i ? host_strb_i : 4'hF;

endmodule
